// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a shared multi-cycle
// ALU (ALU593). A requester's operands/opcode are captured at grant, the ALU
// is started, and a one-cycle done pulse returns the result (or a timeout
// abort flagged by err) to the owner. Every output comes straight from a
// register so nothing combinational leaks from req/alu_done to the outputs.
module alu_arbiter #(
  parameter int unsigned TIMEOUT = 255  // max BUSY cycles without alu_done (1..255)
) (
  input  logic        clk,
  input  logic        reset,
  // requester 0
  input  logic        req0,
  input  logic [7:0]  A0,
  input  logic [7:0]  B0,
  input  logic [3:0]  op0,     // alu_opcode_t
  output logic        gnt0,
  output logic        done0,
  // requester 1
  input  logic        req1,
  input  logic [7:0]  A1,
  input  logic [7:0]  B1,
  input  logic [3:0]  op1,     // alu_opcode_t
  output logic        gnt1,
  output logic        done1,
  // shared response
  output logic        err,
  output logic [15:0] result,
  // ALU593 side
  output logic        alu_start,
  output logic [7:0]  alu_A,
  output logic [7:0]  alu_B,
  output logic [3:0]  alu_op,  // alu_opcode_t
  input  logic        alu_done,
  input  logic [15:0] alu_result
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [7:0]  WD_LIMIT   = 8'(TIMEOUT);
  localparam logic [15:0] ABORT_WORD = 16'hFFFF;

  state_t      state_q;
  logic        owner_q;   // 0 = requester 0, 1 = requester 1
  logic        last_q;    // requester served most recently
  logic [7:0]  wd_q;      // BUSY cycles seen without alu_done
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [3:0]  op_q;
  logic        start_q;
  logic        gnt0_q;
  logic        gnt1_q;
  logic        done0_q;
  logic        done1_q;
  logic        err_q;
  logic [15:0] result_q;

  logic        any_req_d;
  logic        pick_d;
  logic [7:0]  sel_a_d;
  logic [7:0]  sel_b_d;
  logic [3:0]  sel_op_d;
  logic [7:0]  wd_d;
  logic        wd_expire_d;

  // Arbitration pick, operand mux and watchdog increment for the current cycle.
  always_comb begin
    // NOTE: every signal gets a value before any branch so no latch is inferred.
    any_req_d   = req0 | req1;
    pick_d      = 1'b0;
    if (req0 && req1) begin
      pick_d = ~last_q;           // contention: whoever was not served last
    end else if (req1) begin
      pick_d = 1'b1;
    end
    sel_a_d     = pick_d ? A1  : A0;
    sel_b_d     = pick_d ? B1  : B0;
    sel_op_d    = pick_d ? op1 : op0;
    wd_d        = wd_q + 8'd1;
    wd_expire_d = (wd_d == WD_LIMIT);
  end

  // Control FSM with all outputs registered; reset aborts silently.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;           // gives requester 0 priority after reset
      wd_q     <= 8'd0;
      a_q      <= 8'd0;
      b_q      <= 8'd0;
      op_q     <= 4'd0;
      start_q  <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err_q    <= 1'b0;
      result_q <= 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req_d) begin
            owner_q <= pick_d;
            a_q     <= sel_a_d;
            b_q     <= sel_b_d;
            op_q    <= sel_op_d;
            wd_q    <= 8'd0;
            start_q <= 1'b1;
            gnt0_q  <= ~pick_d;
            gnt1_q  <= pick_d;
            state_q <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          if (alu_done) begin
            // Completion wins even on the edge the watchdog would expire.
            result_q <= alu_result;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            done0_q  <= ~owner_q;
            done1_q  <= owner_q;
            state_q  <= ST_RESP;
          end else if (wd_expire_d) begin
            wd_q     <= wd_d;
            result_q <= ABORT_WORD;
            err_q    <= 1'b1;
            start_q  <= 1'b0;
            done0_q  <= ~owner_q;
            done1_q  <= owner_q;
            state_q  <= ST_RESP;
          end else begin
            wd_q <= wd_d;
          end
        end

        ST_RESP: begin
          // Done pulse lasts exactly this one cycle; grant drops with it.
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          last_q  <= owner_q;
          state_q <= ST_IDLE;
        end

        default: begin
          start_q <= 1'b0;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign err       = err_q;
  assign result    = result_q;
  assign alu_start = start_q;
  assign alu_A     = a_q;
  assign alu_B     = b_q;
  assign alu_op    = op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter, built with TIMEOUT=4 so the watchdog
// paths are reachable in a few cycles. Inputs change 1ns after a rising edge
// and outputs are checked at that same point, i.e. after the edge's update.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [7:0]  A0, B0, A1, B1;
  logic [3:0]  op0, op1;
  logic        gnt0, gnt1, done0, done1, err;
  logic [15:0] result;
  logic        alu_start;
  logic [7:0]  alu_A, alu_B;
  logic [3:0]  alu_op;
  logic        alu_done;
  logic [15:0] alu_result;

  int total  = 0;
  int passed = 0;

  alu_arbiter #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .A0        (A0),
    .B0        (B0),
    .op0       (op0),
    .gnt0      (gnt0),
    .done0     (done0),
    .req1      (req1),
    .A1        (A1),
    .B1        (B1),
    .op1       (op1),
    .gnt1      (gnt1),
    .done1     (done1),
    .err       (err),
    .result    (result),
    .alu_start (alu_start),
    .alu_A     (alu_A),
    .alu_B     (alu_B),
    .alu_op    (alu_op),
    .alu_done  (alu_done),
    .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    A0 = 8'h00; B0 = 8'h00; A1 = 8'h00; B1 = 8'h00; op0 = 4'h0; op1 = 4'h0;
    alu_done = 1'b0; alu_result = 16'h0000;
    tick(); tick();
    total++; if (alu_start !== 1'b0) $display("FAIL reset_start: got %b want 0", alu_start); else passed++;
    total++; if ({gnt0, gnt1} !== 2'b00) $display("FAIL reset_gnt: got %b want 00", {gnt0, gnt1}); else passed++;
    total++; if ({done0, done1, err} !== 3'b000) $display("FAIL reset_done_err: got %b want 000", {done0, done1, err}); else passed++;
    total++; if (result !== 16'h0000) $display("FAIL reset_result: got %h want 0000", result); else passed++;
    total++; if ({alu_A, alu_B, alu_op} !== 20'h0) $display("FAIL reset_alu_bus: got %h want 00000", {alu_A, alu_B, alu_op}); else passed++;
    reset = 1'b0;
    tick();
    total++; if (alu_start !== 1'b0) $display("FAIL idle_no_req_start: got %b want 0", alu_start); else passed++;
  endtask

  // Single request from requester 0, ALU finishes in the third BUSY cycle.
  task automatic test_basic();
    req0 = 1'b1; A0 = 8'h12; B0 = 8'h34; op0 = 4'h3;
    tick();
    total++; if ({alu_start, gnt0, gnt1} !== 3'b110) $display("FAIL basic_grant: got start/gnt0/gnt1=%b want 110", {alu_start, gnt0, gnt1}); else passed++;
    total++; if ({alu_A, alu_B, alu_op} !== {8'h12, 8'h34, 4'h3}) $display("FAIL basic_operands: got %h want 12343", {alu_A, alu_B, alu_op}); else passed++;
    tick(); tick();
    alu_done = 1'b1; alu_result = 16'h0046;
    tick();
    alu_done = 1'b0; req0 = 1'b0;
    total++; if ({done0, done1, err} !== 3'b100) $display("FAIL basic_done: got done0/done1/err=%b want 100", {done0, done1, err}); else passed++;
    total++; if (result !== 16'h0046) $display("FAIL basic_result: got %h want 0046", result); else passed++;
    total++; if ({alu_start, gnt0} !== 2'b01) $display("FAIL basic_resp_start_gnt: got %b want 01", {alu_start, gnt0}); else passed++;
    tick();
    total++; if ({done0, gnt0} !== 2'b00) $display("FAIL basic_done_one_cycle: got done0/gnt0=%b want 00", {done0, gnt0}); else passed++;
    total++; if (result !== 16'h0046) $display("FAIL basic_result_hold: got %h want 0046", result); else passed++;
  endtask

  // Requester changes operands and drops req while BUSY; the latched values stay.
  task automatic test_operand_hold();
    req0 = 1'b1; A0 = 8'h56; B0 = 8'h78; op0 = 4'h9;
    tick();
    A0 = 8'hFF; B0 = 8'h01; op0 = 4'h2; req0 = 1'b0;
    tick();
    total++; if ({alu_A, alu_B, alu_op} !== {8'h56, 8'h78, 4'h9}) $display("FAIL hold_busy_operands: got %h want 56789", {alu_A, alu_B, alu_op}); else passed++;
    alu_done = 1'b1; alu_result = 16'h00CE;
    tick();
    alu_done = 1'b0;
    total++; if (done0 !== 1'b1) $display("FAIL hold_done_after_drop: got %b want 1", done0); else passed++;
    total++; if (alu_A !== 8'h56) $display("FAIL hold_alu_a_at_done: got %h want 56", alu_A); else passed++;
    tick();
  endtask

  // No alu_done: alu_start for exactly TIMEOUT cycles, then abort.
  task automatic test_timeout();
    int cnt;
    cnt = 0;
    req1 = 1'b1; A1 = 8'hAA; B1 = 8'h55; op1 = 4'h1;
    tick();
    total++; if ({gnt0, gnt1} !== 2'b01) $display("FAIL timeout_grant1: got %b want 01", {gnt0, gnt1}); else passed++;
    while (alu_start === 1'b1 && cnt < 20) begin
      cnt++;
      tick();
    end
    total++; if (cnt !== 4) $display("FAIL timeout_start_cycles: got %0d want 4", cnt); else passed++;
    total++; if ({done0, done1, err} !== 3'b011) $display("FAIL timeout_done_err: got done0/done1/err=%b want 011", {done0, done1, err}); else passed++;
    total++; if (result !== 16'hFFFF) $display("FAIL timeout_result: got %h want ffff", result); else passed++;
    req1 = 1'b0;
    tick();
    total++; if ({done1, err} !== 2'b01) $display("FAIL timeout_err_hold: got done1/err=%b want 01", {done1, err}); else passed++;
  endtask

  // alu_done while IDLE must be ignored.
  task automatic test_idle_done();
    alu_done = 1'b1; alu_result = 16'h1234;
    tick();
    alu_done = 1'b0;
    total++; if ({done0, done1, alu_start} !== 3'b000) $display("FAIL idle_done_ignored: got %b want 000", {done0, done1, alu_start}); else passed++;
    total++; if (result !== 16'hFFFF) $display("FAIL idle_done_result_hold: got %h want ffff", result); else passed++;
  endtask

  // alu_done on the same edge the watchdog would expire: normal completion wins.
  task automatic test_done_at_expiry();
    req0 = 1'b1; A0 = 8'h0F; B0 = 8'hF0; op0 = 4'h7;
    tick();
    tick(); tick(); tick();
    total++; if (alu_start !== 1'b1) $display("FAIL expiry_still_busy: got %b want 1", alu_start); else passed++;
    alu_done = 1'b1; alu_result = 16'h0BEE;
    tick();
    alu_done = 1'b0; req0 = 1'b0;
    total++; if ({done0, err} !== 2'b10) $display("FAIL expiry_done_wins: got done0/err=%b want 10", {done0, err}); else passed++;
    total++; if (result !== 16'h0BEE) $display("FAIL expiry_result: got %h want 0bee", result); else passed++;
    tick();
  endtask

  // Reset mid-BUSY aborts silently; a fresh request is then served normally.
  task automatic test_reset_mid();
    req0 = 1'b1; A0 = 8'h33; B0 = 8'h44; op0 = 4'h4;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; req0 = 1'b0;
    total++; if ({alu_start, gnt0, gnt1} !== 3'b000) $display("FAIL rstmid_outputs: got start/gnt0/gnt1=%b want 000", {alu_start, gnt0, gnt1}); else passed++;
    total++; if ({done0, done1, err} !== 3'b000) $display("FAIL rstmid_no_done: got %b want 000", {done0, done1, err}); else passed++;
    tick();
    total++; if ({done0, done1} !== 2'b00) $display("FAIL rstmid_no_late_done: got %b want 00", {done0, done1}); else passed++;
    req1 = 1'b1; A1 = 8'h21; B1 = 8'h43; op1 = 4'h5;
    tick();
    total++; if ({gnt0, gnt1, alu_A, alu_B, alu_op} !== {2'b01, 8'h21, 8'h43, 4'h5}) $display("FAIL rstmid_fresh_grant: got %h want %h", {gnt0, gnt1, alu_A, alu_B, alu_op}, {2'b01, 8'h21, 8'h43, 4'h5}); else passed++;
    alu_done = 1'b1; alu_result = 16'h0064;
    tick();
    alu_done = 1'b0; req1 = 1'b0;
    total++; if ({done1, err, result} !== {2'b10, 16'h0064}) $display("FAIL rstmid_fresh_done: got %h want %h", {done1, err, result}, {2'b10, 16'h0064}); else passed++;
    tick();
  endtask

  // Both requesters held high from reset: grants alternate 0,1,0,1.
  task automatic test_round_robin();
    logic [1:0] exp_gnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    A0 = 8'h01; B0 = 8'h02; A1 = 8'h03; B1 = 8'h04;
    for (int i = 0; i < 4; i++) begin
      exp_gnt = (i % 2 == 0) ? 2'b10 : 2'b01;
      tick();
      total++; if ({gnt0, gnt1} !== exp_gnt) $display("FAIL rr_grant_%0d: got gnt0/gnt1=%b want %b", i, {gnt0, gnt1}, exp_gnt); else passed++;
      alu_done = 1'b1; alu_result = 16'(i);
      tick();
      alu_done = 1'b0;
      total++; if ({done0, done1} !== exp_gnt) $display("FAIL rr_done_%0d: got done0/done1=%b want %b", i, {done0, done1}, exp_gnt); else passed++;
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_operand_hold();
    test_timeout();
    test_idle_done();
    test_done_at_expiry();
    test_reset_mid();
    test_round_robin();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish within 100000 ns");
    $fatal(1);
  end

endmodule
